set_assoc_cache: RTL and testbench

//  Clocked N-way set-associative write-back/write-allocate cache between CPU load/store port and block memory.

---
 rtl/cache_pkg.sv | 27 ++
 rtl/cache_lru.sv | 43 ++++
 rtl/set_assoc_cache.sv | 209 ++++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared FSM state type, default geometry and address-field width helpers for the set-associative cache.
// Zero-width fields (index of a fully associative cache) are carried as 1 bit and tied to zero.
package cache_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_WORDS  = 4;
  localparam int DEF_SETS   = 2;
  localparam int DEF_WAYS   = 2;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_RESP} state_t;

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int words, input int sets);
    return addr_w - 2 - $clog2(words) - $clog2(sets);
  endfunction

  function automatic int safe_w(input int w);
    return (w > 0) ? w : 1;
  endfunction
endpackage

// File: rtl/cache_lru.sv
// True-LRU age tracker: per-set ages, 0 = MRU, WAYS-1 = victim; ages always form a permutation.
// Touch takes effect on the next rising edge; victim lookup is combinational; no backpressure.
module cache_lru
  import cache_pkg::*;
#(
  parameter  int SETS   = DEF_SETS,
  parameter  int WAYS   = DEF_WAYS,
  localparam int IDX_SW = safe_w(idx_w(SETS)),
  localparam int WAY_SW = safe_w($clog2(WAYS))
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              touch,
  input  logic [IDX_SW-1:0] set_idx,
  input  logic [WAY_SW-1:0] way,
  output logic [WAY_SW-1:0] victim
);
  logic [WAY_SW-1:0] age [SETS][WAYS];
  logic [WAY_SW-1:0] old_age;

  assign old_age = age[set_idx][way];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= WAY_SW'(w);
    end else if (touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_SW'(w) == way)
          age[set_idx][w] <= '0;
        else if (age[set_idx][w] < old_age)
          age[set_idx][w] <= age[set_idx][w] + WAY_SW'(1);
      end
    end
  end

  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[set_idx][w] == WAY_SW'(WAYS - 1)) victim = WAY_SW'(w);
  end
endmodule

// File: rtl/set_assoc_cache.sv
// N-way write-back/write-allocate cache, true LRU; hit acks 1 cycle after accept, miss 1 cycle after last mem_ack.
// cpu_ready is low outside IDLE (requests ignored, not queued); CACHE_STATS_EN adds hit/miss/write-back counters.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int WORDS  = DEF_WORDS,
  parameter  int SETS   = DEF_SETS,
  parameter  int WAYS   = DEF_WAYS,
  localparam int OFF_W  = off_w(WORDS),
  localparam int IDX_W  = idx_w(SETS),
  localparam int TAG_W  = tag_w(ADDR_W, WORDS, SETS),
  localparam int BLK_W  = DATA_W * WORDS,
  localparam int IDX_SW = safe_w(IDX_W),
  localparam int WAY_SW = safe_w($clog2(WAYS)),
  localparam int LO_W   = ADDR_W - TAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BLK_W-1:0]  mem_wdata,
  input  logic [BLK_W-1:0]  mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [31:0]       wb_cnt
`endif
);
  state_t state, state_nxt;

  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [WAY_SW-1:0] vic_way;

  logic [TAG_W-1:0]  tag_arr   [SETS][WAYS];
  logic [DATA_W-1:0] data_arr  [SETS][WAYS][WORDS];
  logic [WAYS-1:0]   valid_arr [SETS];
  logic [WAYS-1:0]   dirty_arr [SETS];

  logic [TAG_W-1:0]  cpu_tag, req_tag;
  logic [OFF_W-1:0]  cpu_off, req_off;
  logic [IDX_SW-1:0] cpu_idx, req_idx, lru_set;
  logic              hit, inv_found, vic_dirty, accept, fill_done;
  logic [WAY_SW-1:0] hit_way, inv_way, lru_victim, vic_sel, lru_way;
  logic [ADDR_W-1:0] fill_addr, wb_addr;
  logic              unused_bits;

  assign cpu_tag     = cpu_addr[ADDR_W-1 -: TAG_W];
  assign req_tag     = req_addr[ADDR_W-1 -: TAG_W];
  assign cpu_off     = cpu_addr[2 +: OFF_W];
  assign req_off     = req_addr[2 +: OFF_W];
  assign unused_bits = ^{cpu_addr[1:0], req_addr[1:0]};

  generate
    if (IDX_W > 0) begin : g_idx
      assign cpu_idx = cpu_addr[2+OFF_W +: IDX_SW];
      assign req_idx = req_addr[2+OFF_W +: IDX_SW];
    end else begin : g_no_idx
      assign cpu_idx = '0;
      assign req_idx = '0;
    end
  endgenerate

  assign fill_addr = {req_addr[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
  assign wb_addr   = {tag_arr[req_idx][vic_way], fill_addr[LO_W-1:0]};

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_arr[cpu_idx][w] && tag_arr[cpu_idx][w] == cpu_tag) begin
        hit     = 1'b1;
        hit_way = WAY_SW'(w);
      end
      if (!valid_arr[cpu_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_SW'(w);
      end
    end
  end

  assign vic_sel   = inv_found ? inv_way : lru_victim;
  assign vic_dirty = valid_arr[cpu_idx][vic_sel] & dirty_arr[cpu_idx][vic_sel];
  assign accept    = (state == S_IDLE) && cpu_req;
  assign fill_done = (state == S_FILL) && mem_ack;
  assign lru_set   = (state == S_IDLE) ? cpu_idx : req_idx;
  assign lru_way   = (state == S_IDLE) ? hit_way : vic_way;

  cache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
    .clk     (clk),
    .reset   (reset),
    .touch   ((accept && hit) || fill_done),
    .set_idx (lru_set),
    .way     (lru_way),
    .victim  (lru_victim)
  );

  always_comb begin
    state_nxt = state;
    cpu_ready = 1'b0;
    cpu_ack   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req) state_nxt = hit ? S_RESP : (vic_dirty ? S_WB : S_FILL);
      end
      S_WB: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = wb_addr;
        for (int i = 0; i < WORDS; i++)
          mem_wdata[i*DATA_W +: DATA_W] = data_arr[req_idx][vic_way][i];
        if (mem_ack) state_nxt = S_FILL;
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = fill_addr;
        if (mem_ack) state_nxt = S_RESP;
      end
      S_RESP: begin
        cpu_ack   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      vic_way   <= '0;
      cpu_rdata <= '0;
      cpu_hit   <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_arr[s] <= '0;
        dirty_arr[s] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_we    <= cpu_we;
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
        vic_way   <= vic_sel;
        if (hit) begin
          cpu_hit   <= 1'b1;
          cpu_rdata <= cpu_we ? cpu_wdata : data_arr[cpu_idx][hit_way][cpu_off];
          if (cpu_we) dirty_arr[cpu_idx][hit_way] <= 1'b1;
        end
      end
      if (fill_done) begin
        cpu_hit   <= 1'b0;
        cpu_rdata <= req_we ? req_wdata : mem_rdata[req_off*DATA_W +: DATA_W];
        valid_arr[req_idx][vic_way] <= 1'b1;
        dirty_arr[req_idx][vic_way] <= req_we;
      end
    end
  end

  // Tag and data storage are left uninitialised; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (accept && hit && cpu_we)
      data_arr[cpu_idx][hit_way][cpu_off] <= cpu_wdata;
    if (fill_done) begin
      tag_arr[req_idx][vic_way] <= req_tag;
      for (int i = 0; i < WORDS; i++)
        data_arr[req_idx][vic_way][i] <= (req_we && OFF_W'(i) == req_off) ?
                                         req_wdata : mem_rdata[i*DATA_W +: DATA_W];
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (cpu_ack && cpu_hit)           hit_cnt  <= hit_cnt + 32'd1;
      if (cpu_ack && !cpu_hit)          miss_cnt <= miss_cnt + 32'd1;
      if ((state == S_WB) && mem_ack)   wb_cnt   <= wb_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed + randomised bench for set_assoc_cache; the reference keeps lines per set and picks the
// LRU victim by last-use timestamp, with its own copy of memory to predict refills and write-backs.
`timescale 1ns/1ps
module tb_set_assoc_cache;
  localparam int ADDR_W = 10, DATA_W = 32, WORDS = 4, SETS = 2, WAYS = 2;
  localparam int BLK_W = DATA_W * WORDS, NBLK = 64;

  logic              clk = 1'b0, reset = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ready, cpu_ack, cpu_hit, mem_req, mem_we;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [BLK_W-1:0]  mem_wdata, mem_rdata;
  logic              mem_ack;
`ifdef CACHE_STATS_EN
  logic [31:0]       hit_cnt, miss_cnt, wb_cnt;
`endif

  set_assoc_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_hit(cpu_hit), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  int checks = 0, errors = 0;
  int unsigned cyc = 0, last_ack_cyc = 0;
  int n_hit = 0, n_miss = 0, n_wb = 0;

  // Environment memory: acks on the third cycle it sees a request, logs every completed transfer.
  logic [DATA_W-1:0] env_mem [NBLK][WORDS];
  bit                log_we[$];
  logic [ADDR_W-1:0] log_addr[$];
  logic [BLK_W-1:0]  log_wdata[$];

  initial begin : mem_model
    int cnt;
    int blk;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (reset) begin
        cnt = 0;
        mem_ack = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_req) begin
        cnt++;
        if (cnt == 3) begin
          blk = int'(mem_addr[9:4]);
          log_we.push_back(mem_we);
          log_addr.push_back(mem_addr);
          log_wdata.push_back(mem_wdata);
          for (int i = 0; i < WORDS; i++) begin
            if (mem_we) env_mem[blk][i] = mem_wdata[i*DATA_W +: DATA_W];
            else mem_rdata[i*DATA_W +: DATA_W] = env_mem[blk][i];
          end
          mem_ack = 1'b1;
          last_ack_cyc = cyc;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Reference model
  logic [4:0]        m_tag   [SETS][WAYS];
  bit                m_valid [SETS][WAYS];
  bit                m_dirty [SETS][WAYS];
  logic [DATA_W-1:0] m_data  [SETS][WAYS][WORDS];
  int                m_last  [SETS][WAYS];
  int                tick;
  logic [DATA_W-1:0] ref_mem [NBLK][WORDS];

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_last[s][w]  = -w;
      end
    tick = 0;
    n_hit = 0; n_miss = 0; n_wb = 0;
  endtask

  task automatic do_access(input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                           input bit noise);
    int s, off, blk, way, oblk, n;
    bit exp_hit, got;
    logic [DATA_W-1:0] exp_rd;
    bit                e_we[$];
    logic [ADDR_W-1:0] e_addr[$];
    logic [BLK_W-1:0]  e_wdata[$];
    logic [BLK_W-1:0]  blkv;
    s = int'(addr[4]); off = int'(addr[3:2]); blk = int'(addr[9:4]);
    exp_hit = 0; way = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == addr[9:5]) begin exp_hit = 1; way = w; end
    if (!exp_hit) begin
      for (int w = 0; w < WAYS; w++) if (!m_valid[s][w] && way < 0) way = w;
      if (way < 0) begin
        way = 0;
        for (int w = 1; w < WAYS; w++) if (m_last[s][w] < m_last[s][way]) way = w;
      end
      if (m_valid[s][way] && m_dirty[s][way]) begin
        oblk = int'(m_tag[s][way]) * 2 + s;
        for (int i = 0; i < WORDS; i++) begin
          blkv[i*DATA_W +: DATA_W] = m_data[s][way][i];
          ref_mem[oblk][i] = m_data[s][way][i];
        end
        e_we.push_back(1); e_addr.push_back(ADDR_W'(oblk * 16)); e_wdata.push_back(blkv);
        n_wb++;
      end
      e_we.push_back(0); e_addr.push_back(ADDR_W'(blk * 16)); e_wdata.push_back('0);
      for (int i = 0; i < WORDS; i++) m_data[s][way][i] = ref_mem[blk][i];
      m_tag[s][way] = addr[9:5]; m_valid[s][way] = 1; m_dirty[s][way] = 0;
    end
    if (we) begin m_data[s][way][off] = wd; m_dirty[s][way] = 1; end
    exp_rd = m_data[s][way][off];
    tick++; m_last[s][way] = tick;
    if (exp_hit) n_hit++; else n_miss++;

    @(negedge clk);
    n = 0;
    while (cpu_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (cpu_ready !== 1'b1) begin errors++; $display("FAIL ready_wait: cpu_ready=%b required 1", cpu_ready); end
    log_we.delete(); log_addr.delete(); log_wdata.delete();
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    n = 0; got = 0;
    while (!got && n < 200) begin
      @(negedge clk); n++;
      if (noise && !exp_hit && n == 2) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = ADDR_W'($urandom); cpu_wdata = $urandom;
      end
      if (noise && !exp_hit && n == 3) cpu_req = 1'b0;
      if (cpu_ack === 1'b1) got = 1;
    end
    cpu_req = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL ack_timeout: addr=%h no cpu_ack within %0d cycles", addr, n); end
    checks++;
    if (cpu_hit !== exp_hit) begin errors++; $display("FAIL hit: addr=%h got %b required %b", addr, cpu_hit, exp_hit); end
    if (!we) begin
      checks++;
      if (cpu_rdata !== exp_rd) begin errors++; $display("FAIL rdata: addr=%h got %h required %h", addr, cpu_rdata, exp_rd); end
    end
    checks++;
    if (exp_hit && n != 1) begin errors++; $display("FAIL hit_latency: addr=%h got %0d cycles required 1", addr, n); end
    else if (!exp_hit && cyc != last_ack_cyc + 1) begin
      errors++; $display("FAIL miss_latency: addr=%h ack cycle %0d required %0d", addr, cyc, last_ack_cyc + 1);
    end
    checks++;
    if (log_we.size() != e_we.size()) begin
      errors++; $display("FAIL mem_txn_count: addr=%h got %0d required %0d", addr, log_we.size(), e_we.size());
    end else begin
      for (int k = 0; k < e_we.size(); k++) begin
        checks++;
        if (log_we[k] !== e_we[k] || log_addr[k] !== e_addr[k] || (e_we[k] && log_wdata[k] !== e_wdata[k])) begin
          errors++;
          $display("FAIL mem_txn%0d: got we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h", k,
                   log_we[k], log_addr[k], log_wdata[k], e_we[k], e_addr[k], e_wdata[k]);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1 || cpu_ack !== 1'b0 || cpu_hit !== 1'b0 || cpu_rdata !== '0) begin
      errors++; $display("FAIL reset_cpu: ready=%b ack=%b hit=%b rdata=%h required 1 0 0 0", cpu_ready, cpu_ack, cpu_hit, cpu_rdata);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++; $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h required all 0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL after_reset: ready=%b mem_req=%b required 1 0", cpu_ready, mem_req);
    end
  endtask

  task automatic test_directed();
    do_access(0, 10'h000, '0, 0);
    do_access(0, 10'h004, '0, 0);
    do_access(1, 10'h008, 32'hDEADBEEF, 0);
    checks++;
    if (log_we.size() != 0) begin errors++; $display("FAIL write_hit_mem: got %0d mem txns required 0", log_we.size()); end
    do_access(0, 10'h020, '0, 0);
    do_access(0, 10'h000, '0, 0);
    do_access(0, 10'h040, '0, 0);
    checks++;
    if (log_we.size() != 1) begin errors++; $display("FAIL clean_evict: got %0d mem txns required 1", log_we.size()); end
    do_access(0, 10'h000, '0, 0);
    do_access(0, 10'h060, '0, 0);
    do_access(0, 10'h080, '0, 0);
    checks++;
    if (log_we.size() == 0 || log_we[0] !== 1'b1 || log_wdata[0][95:64] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL dirty_evict: txns=%0d first_we=%b word2=%h required we=1 word2=deadbeef",
                         log_we.size(), (log_we.size() > 0) ? log_we[0] : 1'b0,
                         (log_wdata.size() > 0) ? log_wdata[0][95:64] : 32'h0);
    end
    do_access(1, 10'h3F0, 32'hCAFEF00D, 0);
    do_access(0, 10'h3F0, '0, 0);
    checks++;
    if (cpu_hit !== 1'b1 || cpu_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL write_miss_readback: hit=%b rdata=%h required 1 cafef00d", cpu_hit, cpu_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] v;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      a = ADDR_W'($urandom_range(0, 255) * 4);
      do_access(1, a, v, 0);
      do_access(0, a, '0, 0);
      checks++;
      if (cpu_rdata !== v) begin errors++; $display("FAIL back_to_back: addr=%h got %h required %h", a, cpu_rdata, v); end
    end
  endtask

  task automatic test_random();
    int blk;
    for (int i = 0; i < 400; i++) begin
      blk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NBLK - 1) : $urandom_range(0, 7);
      do_access(1'($urandom), ADDR_W'(blk * 16 + $urandom_range(0, 15)), $urandom, (i % 5) == 0);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_access(1, 10'h010, 32'h11111111, 0);
    do_access(1, 10'h030, 32'h33333333, 0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h050;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(mem_req === 1'b1 && mem_we === 1'b1) && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!(mem_req === 1'b1 && mem_we === 1'b1)) begin errors++; $display("FAIL wb_start: mem_req=%b mem_we=%b required 1 1", mem_req, mem_we); end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || cpu_ready !== 1'b1 || cpu_ack !== 1'b0) begin
      errors++; $display("FAIL reset_mid: mem_req=%b ready=%b ack=%b required 0 1 0", mem_req, cpu_ready, cpu_ack);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    do_access(0, 10'h010, '0, 0);
    checks++;
    if (cpu_hit !== 1'b0) begin errors++; $display("FAIL post_reset_miss: hit=%b required 0", cpu_hit); end
  endtask

  task automatic test_stats();
`ifdef CACHE_STATS_EN
    @(negedge clk);
    checks++;
    if (hit_cnt !== 32'(n_hit) || miss_cnt !== 32'(n_miss) || wb_cnt !== 32'(n_wb)) begin
      errors++; $display("FAIL stats: got %0d/%0d/%0d required %0d/%0d/%0d", hit_cnt, miss_cnt, wb_cnt, n_hit, n_miss, n_wb);
    end
`endif
  endtask

  initial begin
    for (int b = 0; b < NBLK; b++)
      for (int i = 0; i < WORDS; i++) begin
        env_mem[b][i] = 32'(b * 4 + i);
        ref_mem[b][i] = 32'(b * 4 + i);
      end
    model_reset();
    repeat (3) @(posedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_stats();
    test_reset_mid();
    test_random();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
